single_transpose_stream: RTL and testbench



---
 rtl/single_transpose_pkg.sv | 19 +
 rtl/single_transpose.sv | 22 ++
 rtl/single_transpose_bank.sv | 35 +++
 rtl/single_transpose_stream.sv | 192 +++++++++++++++++++
 tb/tb_single_transpose_stream.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/single_transpose_pkg.sv
// single_transpose_pkg
// Shared types and helpers for the single-precision transpose stream.
//   state_e : single-bank sequencer states (FILL, DRAIN)
//   elem_t  : one 32-bit float element, routed without modification
//   cw(n)   : counter width for a bound n, never less than 1 bit
package single_transpose_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef logic [31:0] elem_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/single_transpose.sv
// single_transpose
// Purely combinational matrix transpose: m_out_o[j][i] = m_in_i[i][j].
// Ports:
//   m_in_i  : WIDTH x HEIGHT input matrix
//   m_out_o : HEIGHT x WIDTH transposed matrix
module single_transpose
  import single_transpose_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  elem_t [WIDTH-1:0][HEIGHT-1:0] m_in_i,
  output elem_t [HEIGHT-1:0][WIDTH-1:0] m_out_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < HEIGHT; j++) begin : g_col
      assign m_out_o[j][i] = m_in_i[i][j];
    end
  end

endmodule

// File: rtl/single_transpose_bank.sv
// single_transpose_bank
// WIDTH x HEIGHT element register array with one write port and the whole
// matrix presented on the output. Contents are intentionally not reset.
// Ports:
//   clk_i  : clock
//   en_i   : write enable
//   i_i    : row index of the element being written
//   j_i    : column index of the element being written
//   data_i : element to store
//   m_o    : full matrix contents
module single_transpose_bank
  import single_transpose_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic                              clk_i,
  input  logic                              en_i,
  input  logic [cw(WIDTH)-1:0]              i_i,
  input  logic [cw(HEIGHT)-1:0]             j_i,
  input  elem_t                             data_i,
  output elem_t [WIDTH-1:0][HEIGHT-1:0]     m_o
);

  elem_t [WIDTH-1:0][HEIGHT-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[i_i][j_i] <= data_i;
    end
  end

  assign m_o = mem_q;

endmodule

// File: rtl/single_transpose_stream.sv
// single_transpose_stream
// Accepts a WIDTH x HEIGHT matrix row-major (i outer, j inner), buffers it in
// a register bank and replays the transpose column-major (j outer, i inner).
// Optional feature macro: SINGLE_TRANSPOSE_PINGPONG_EN selects two banks for
// full-rate streaming; without it a single bank alternates FILL / DRAIN.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake; in_data element, in_last frame end
//   out_valid/out_ready   : output handshake; out_data element, out_last end
//   busy                  : partial frame being written or a bank holds data
//   err                   : sticky framing error (in_last misplaced/missing)
module single_transpose_stream
  import single_transpose_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  localparam int IW = cw(WIDTH);
  localparam int JW = cw(HEIGHT);
  localparam logic [IW-1:0] I_MAX = IW'(WIDTH - 1);
  localparam logic [JW-1:0] J_MAX = JW'(HEIGHT - 1);
`ifdef SINGLE_TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [IW-1:0] wi_q, ri_q;
  logic [JW-1:0] wj_q, rj_q;
  logic          err_q;
  logic          wr_fire, rd_fire, wr_final, rd_final;
  logic [NB-1:0] bank_we;
  logic [NB-1:0] full;

  elem_t [HEIGHT-1:0][WIDTH-1:0] tout [NB];
  elem_t [HEIGHT-1:0][WIDTH-1:0] sel_m;

  assign wr_final = (wi_q == I_MAX) && (wj_q == J_MAX);
  assign rd_final = (rj_q == J_MAX) && (ri_q == I_MAX);
  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;

  // Write counters (i outer, j inner), read counters (j outer, i inner),
  // and the sticky framing error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wi_q  <= '0;
      wj_q  <= '0;
      ri_q  <= '0;
      rj_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wj_q == J_MAX) begin
          wj_q <= '0;
          wi_q <= (wi_q == I_MAX) ? '0 : wi_q + 1'b1;
        end else begin
          wj_q <= wj_q + 1'b1;
        end
        // in_last must coincide exactly with the final element.
        if (in_last != wr_final) begin
          err_q <= 1'b1;
        end
      end
      if (rd_fire) begin
        if (ri_q == I_MAX) begin
          ri_q <= '0;
          rj_q <= (rj_q == J_MAX) ? '0 : rj_q + 1'b1;
        end else begin
          ri_q <= ri_q + 1'b1;
        end
      end
    end
  end

`ifdef SINGLE_TRANSPOSE_PINGPONG_EN
  logic [1:0] full_q;
  logic       wb_q, rb_q;

  // Write and read never target the same bank in one cycle: writing needs
  // the bank empty, reading needs it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 2'b00;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
    end else begin
      if (wr_fire && wr_final) begin
        full_q[wb_q] <= 1'b1;
        wb_q         <= ~wb_q;
      end
      if (rd_fire && rd_final) begin
        full_q[rb_q] <= 1'b0;
        rb_q         <= ~rb_q;
      end
    end
  end

  assign in_ready  = !full_q[wb_q] && !reset;
  assign out_valid = full_q[rb_q] && !reset;
  assign full      = full_q;
  assign bank_we   = {wr_fire && wb_q, wr_fire && !wb_q};
  assign sel_m     = tout[rb_q];
`else
  state_e state_q;
  logic   in_ready_q, out_valid_q;

  // state | meaning
  // FILL  | accepting input elements into the bank
  // DRAIN | bank full, replaying the transposed matrix
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (wr_fire && wr_final) begin
            state_q     <= DRAIN;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (rd_fire && rd_final) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= FILL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gating with reset keeps in_ready low during the reset cycle itself.
  assign in_ready  = in_ready_q && !reset;
  assign out_valid = out_valid_q && !reset;
  assign full      = out_valid_q;
  assign bank_we   = wr_fire;
  assign sel_m     = tout[0];
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    elem_t [WIDTH-1:0][HEIGHT-1:0] m;

    single_transpose_bank #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT)
    ) u_bank (
      .clk_i (clk),
      .en_i  (bank_we[b]),
      .i_i   (wi_q),
      .j_i   (wj_q),
      .data_i(in_data),
      .m_o   (m)
    );

    single_transpose #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT)
    ) u_transpose (
      .m_in_i (m),
      .m_out_o(tout[b])
    );
  end

  assign out_data = sel_m[rj_q][ri_q];
  assign out_last = out_valid && rd_final;
  assign busy     = (wi_q != '0) || (wj_q != '0) || (|full);
  assign err      = err_q;

endmodule

// File: tb/tb_single_transpose_stream.sv
module tb_single_transpose_stream;
  import single_transpose_pkg::*;

  localparam int W  = 2;
  localparam int H  = 3;
  localparam int WH = W * H;
`ifdef SINGLE_TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_last, busy, err;
  logic [31:0] out_data;

  logic        r1 = 1'b1, v1 = 1'b0, l1 = 1'b0, ordy1 = 1'b0;
  logic [31:0] d1 = '0;
  logic        irdy1, oval1, olast1, busy1, err1;
  logic [31:0] odata1;

  single_transpose_stream #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  single_transpose_stream #(.WIDTH(1), .HEIGHT(1)) dut1 (
    .clk(clk), .reset(r1), .in_valid(v1), .in_ready(irdy1),
    .in_data(d1), .in_last(l1), .out_valid(oval1),
    .out_ready(ordy1), .out_data(odata1), .out_last(olast1),
    .busy(busy1), .err(err1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: accepted elements of the current frame, and the queue
  // of transposed elements still owed to the consumer.
  elem_t in_buf[$];
  elem_t exp_q[$];
  logic  expl_q[$];
  logic  err_m = 1'b0;

  logic        s_valid, s_last, s_inrdy, s_busy, s_err;
  logic [31:0] s_data;

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic iv, input logic [31:0] id,
                      input logic il, input logic ordy);
    int  pend;
    bit  fin;
    reset = rst; in_valid = iv; in_data = id; in_last = il; out_ready = ordy;
    @(negedge clk);
    s_valid = out_valid; s_last = out_last; s_data = out_data;
    s_inrdy = in_ready;  s_busy = busy;     s_err  = err;
    if (rst) begin
      check1("rst_in_ready", in_ready, 1'b0);
      check1("rst_out_valid", out_valid, 1'b0);
      in_buf.delete(); exp_q.delete(); expl_q.delete(); err_m = 1'b0;
    end else begin
      pend = (exp_q.size() + WH - 1) / WH;
      check1("in_ready", in_ready, pend < NB);
      check1("out_valid", out_valid, pend != 0);
      check1("busy", busy, (in_buf.size() != 0) || (pend != 0));
      check1("err", err, err_m);
      if (out_valid && exp_q.size() != 0) begin
        check32("out_data", out_data, exp_q[0]);
        check1("out_last", out_last, expl_q[0]);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(expl_q.pop_front());
      end
      if (in_valid && in_ready) begin
        fin = (in_buf.size() == WH - 1);
        if (in_last != fin) err_m = 1'b1;
        in_buf.push_back(in_data);
        if (fin) begin
          for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++) begin
              exp_q.push_back(in_buf[i * H + j]);
              expl_q.push_back(j == H - 1 && i == W - 1);
            end
          in_buf.delete();
        end
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic        dlast;
    logic [31:0] dout;
    logic        olast;
  } vec_t;

  vec_t        tbl[WH];
  logic [31:0] exp2[WH];

  initial begin
    tbl[0] = '{32'd1, 1'b0, 32'd1, 1'b0};
    tbl[1] = '{32'd2, 1'b0, 32'd4, 1'b0};
    tbl[2] = '{32'd3, 1'b0, 32'd2, 1'b0};
    tbl[3] = '{32'd4, 1'b0, 32'd5, 1'b0};
    tbl[4] = '{32'd5, 1'b0, 32'd3, 1'b0};
    tbl[5] = '{32'd6, 1'b1, 32'd6, 1'b1};
    exp2[0] = 32'd7; exp2[1] = 32'd10; exp2[2] = 32'd8;
    exp2[3] = 32'd11; exp2[4] = 32'd9; exp2[5] = 32'd12;

    // Basic frame: table-driven input and output
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check1("reset_busy", s_busy, 1'b0);
    check1("reset_err", s_err, 1'b0);
    check1("reset_in_ready", s_inrdy, 1'b1);
    for (int k = 0; k < WH; k++) step(0, 1, tbl[k].din, tbl[k].dlast, 0);
    for (int k = 0; k < WH; k++) begin
      step(0, 0, 0, 0, 1);
      check1("t1_valid", s_valid, 1'b1);
      check32("t1_data", s_data, tbl[k].dout);
      check1("t1_last", s_last, tbl[k].olast);
    end
    step(0, 0, 0, 0, 1);
    check1("t1_err", s_err, 1'b0);
    check1("t1_idle_valid", s_valid, 1'b0);

    // Back-pressure mid-drain
    for (int k = 0; k < WH; k++) step(0, 1, tbl[k].din, tbl[k].dlast, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 32'hDEAD0000 + k, 0, 0);
      check32("stall_hold", s_data, 32'd2);
      check1("stall_valid", s_valid, 1'b1);
`ifndef SINGLE_TRANSPOSE_PINGPONG_EN
      check1("stall_in_ready", s_inrdy, 1'b0);
`endif
    end
    // Pingpong may have accepted stall-cycle inputs; clear them with reset.
    for (int k = 2; k < WH; k++) begin
      step(0, 0, 0, 0, 1);
      check32("after_stall", s_data, tbl[k].dout);
    end

    // Reset mid-frame
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, tbl[k].din, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check1("mid_reset_busy", s_busy, 1'b0);
    for (int k = 0; k < WH; k++) step(0, 1, 7 + k, k == WH - 1, 0);
    for (int k = 0; k < WH; k++) begin
      step(0, 0, 0, 0, 1);
      check32("t3_data", s_data, exp2[k]);
    end

    // Framing errors
    for (int k = 0; k < WH; k++) step(0, 1, tbl[k].din, k == 2 || k == 5, 0);
    for (int k = 0; k < WH; k++) begin
      step(0, 0, 0, 0, 1);
      check32("t4a_data", s_data, tbl[k].dout);
    end
    check1("t4_err_set", s_err, 1'b1);
    for (int k = 0; k < WH; k++) step(0, 1, 20 + k, 0, 0);
    for (int k = 0; k < WH; k++) begin
      step(0, 0, 0, 0, 1);
      check32("t4b_data", s_data, 20 + (k % W) * H + (k / W));
    end
    check1("t4_err_sticky", s_err, 1'b1);

`ifdef SINGLE_TRANSPOSE_PINGPONG_EN
    // Back-to-back frames at full rate
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 4 * WH; c++) begin
      step(0, 1, 100 + c, (c % WH) == WH - 1, 1);
      check1("pp_in_ready", s_inrdy, 1'b1);
      if (c >= WH) check1("pp_out_valid", s_valid, 1'b1);
    end
`endif

    // Randomized traffic against the model
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      logic iv, il;
      iv = ($urandom % 4) != 0;
      il = (in_buf.size() == WH - 1);
      if (($urandom % 25) == 0) il = ~il;
      step(0, iv, $urandom, il, ($urandom % 3) != 0);
    end
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) step(0, 0, 0, 0, 1);
    check1("drain_done", exp_q.size() == 0, 1'b1);

    // 1x1 matrix
    @(posedge clk); #1;
    r1 = 1'b0; v1 = 1'b1; d1 = 32'h3F800000; l1 = 1'b1; ordy1 = 1'b0;
    @(negedge clk);
    check1("w1_in_ready", irdy1, 1'b1);
    check1("w1_valid0", oval1, 1'b0);
    @(posedge clk); #1;
    v1 = 1'b0; l1 = 1'b0;
    @(negedge clk);
    check1("w1_valid", oval1, 1'b1);
    check32("w1_data", odata1, 32'h3F800000);
    check1("w1_last", olast1, 1'b1);
    check1("w1_busy", busy1, 1'b1);
    ordy1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check1("w1_valid_after", oval1, 1'b0);
    check1("w1_err", err1, 1'b0);
    check1("w1_in_ready_after", irdy1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
